// File: rtl/ariane_pkg.sv
// Core-wide data cache geometry shared by the cache units.
// Only the constants the lookup path relies on are carried in this slice.
package ariane_pkg;

  localparam int unsigned DCACHE_SET_ASSOC    = 8;
  localparam int unsigned DCACHE_INDEX_WIDTH  = 12;
  localparam int unsigned DCACHE_TAG_WIDTH    = 44;
  localparam int unsigned DCACHE_LINE_WIDTH   = 128;
  localparam int unsigned DCACHE_OFFSET_WIDTH = 4;

endpackage

// File: rtl/std_cache_pkg.sv
// Standard write-back data cache types shared by the cache units.
// Only the line record used by the lookup path is carried in this slice.
package std_cache_pkg;

  import ariane_pkg::DCACHE_TAG_WIDTH;
  import ariane_pkg::DCACHE_LINE_WIDTH;

  typedef struct packed {
    logic [DCACHE_TAG_WIDTH-1:0]  tag;
    logic [DCACHE_LINE_WIDTH-1:0] data;
    logic                         valid;
    logic                         dirty;
  } cache_line_t;

endpackage

// File: rtl/cl_word_sel.sv
// Way select for a tag-compare result: counts hit bits, flags multi-hit,
// and extracts the addressed 64-bit word from the single hitting line.
module cl_word_sel
  import std_cache_pkg::*;
#(
  parameter int unsigned WAYS   = 8,
  parameter int unsigned WSEL_W = ariane_pkg::DCACHE_OFFSET_WIDTH - 3
) (
  input  logic [WAYS-1:0]         hit_way_i,
  input  cache_line_t [WAYS-1:0]  rdata_i,
  input  logic [WSEL_W-1:0]       word_sel_i,
  output logic                    hit_o,
  output logic                    err_o,
  output logic [WAYS-1:0]         way_o,
  output logic [63:0]             data_o
);

  localparam int unsigned LINE_W = ariane_pkg::DCACHE_LINE_WIDTH;
  localparam int unsigned WORDS  = LINE_W / 64;
  localparam int unsigned CNT_W  = $clog2(WAYS + 1);

  logic [CNT_W-1:0]       cnt;
  logic [LINE_W-1:0]      line;
  logic [WORDS-1:0][63:0] words;
  logic                   unused_meta;

  // OR-merge is exact when one way hits; other cases are zeroed below
  always_comb begin
    cnt         = '0;
    line        = '0;
    unused_meta = 1'b0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      cnt  = cnt + CNT_W'(hit_way_i[i]);
      line = line | ({LINE_W{hit_way_i[i]}} & rdata_i[i].data);
      unused_meta = unused_meta ^
        (^{rdata_i[i].tag, rdata_i[i].valid, rdata_i[i].dirty});
    end
  end

  assign words  = line;
  assign hit_o  = (cnt == CNT_W'(1));
  assign err_o  = (cnt > CNT_W'(1));
  assign way_o  = hit_o ? hit_way_i : '0;
  assign data_o = hit_o ? words[word_sel_i] : '0;

endmodule

// File: rtl/cache_lookup_req.sv
// Single-port data cache lookup: index phase request, tag phase compare,
// then a held response until the client takes it.
module cache_lookup_req
  import std_cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 64,
  parameter int unsigned DCACHE_SET_ASSOC = 8
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    req_valid_i,
  output logic                                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]                   req_addr_i,
  input  logic                                    kill_i,
  output logic [DCACHE_SET_ASSOC-1:0]             req_o,
  input  logic                                    gnt_i,
  output logic [ariane_pkg::DCACHE_INDEX_WIDTH-1:0] addr_o,
  output logic [ariane_pkg::DCACHE_TAG_WIDTH-1:0] tag_o,
  input  logic [DCACHE_SET_ASSOC-1:0]             hit_way_i,
  input  cache_line_t [DCACHE_SET_ASSOC-1:0]      rdata_i,
  output logic                                    rsp_valid_o,
  input  logic                                    rsp_ready_i,
  output logic                                    rsp_hit_o,
  output logic                                    rsp_err_o,
  output logic [DCACHE_SET_ASSOC-1:0]             rsp_way_o,
  output logic [63:0]                             rsp_data_o
);

  localparam int unsigned IDX_W  = ariane_pkg::DCACHE_INDEX_WIDTH;
  localparam int unsigned TAG_W  = ariane_pkg::DCACHE_TAG_WIDTH;
  localparam int unsigned WSEL_W = ariane_pkg::DCACHE_OFFSET_WIDTH - 3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CMP,
    RSP
  } state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0]            index_q;
  logic [TAG_W-1:0]            tag_q;
  logic [WSEL_W-1:0]           wsel_q;
  logic                        hit_q, err_q;
  logic [DCACHE_SET_ASSOC-1:0] way_q;
  logic [63:0]                 data_q;

  logic                        accept, sample;
  logic                        sel_hit, sel_err;
  logic [DCACHE_SET_ASSOC-1:0] sel_way;
  logic [63:0]                 sel_data;
  logic                        unused_addr;

  assign unused_addr = ^req_addr_i[ADDR_WIDTH-1:TAG_W+IDX_W];

  cl_word_sel #(
    .WAYS   (DCACHE_SET_ASSOC),
    .WSEL_W (WSEL_W)
  ) i_word_sel (
    .hit_way_i  (hit_way_i),
    .rdata_i    (rdata_i),
    .word_sel_i (wsel_q),
    .hit_o      (sel_hit),
    .err_o      (sel_err),
    .way_o      (sel_way),
    .data_o     (sel_data)
  );

  // kill drops the request and response strobes in the cycle it arrives
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    sample      = 1'b0;
    req_o       = '0;
    rsp_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (kill_i) begin
          state_d = IDLE;
        end else begin
          req_o = '1;
          if (gnt_i) state_d = CMP;
        end
      end
      CMP: begin
        if (kill_i) begin
          state_d = IDLE;
        end else begin
          sample  = 1'b1;
          state_d = RSP;
        end
      end
      RSP: begin
        if (kill_i) begin
          state_d = IDLE;
        end else begin
          rsp_valid_o = 1'b1;
          if (rsp_ready_i) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      index_q <= '0;
      tag_q   <= '0;
      wsel_q  <= '0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
      way_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        index_q <= req_addr_i[IDX_W-1:0];
        tag_q   <= req_addr_i[TAG_W+IDX_W-1:IDX_W];
        wsel_q  <= req_addr_i[3 +: WSEL_W];
      end
      if (sample) begin
        hit_q  <= sel_hit;
        err_q  <= sel_err;
        way_q  <= sel_way;
        data_q <= sel_data;
      end
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign addr_o      = index_q;
  assign tag_o       = tag_q;
  assign rsp_hit_o   = hit_q;
  assign rsp_err_o   = err_q;
  assign rsp_way_o   = way_q;
  assign rsp_data_o  = data_q;

endmodule

// File: tb/tb_cache_lookup_req.sv
// Randomized and directed bench for the cache lookup port, checked against
// a behavioural model of the hit / miss / multi-hit response rules.
module tb_cache_lookup_req;
  import std_cache_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_ni;
  logic             req_valid, req_ready;
  logic [63:0]      req_addr;
  logic             kill, gnt;
  logic [7:0]       req_o, hit_way;
  logic [11:0]      addr_o;
  logic [43:0]      tag_o;
  cache_line_t [7:0] rdata;
  logic             rsp_valid, rsp_ready, rsp_hit, rsp_err;
  logic [7:0]       rsp_way;
  logic [63:0]      rsp_data;

  int checks = 0;
  int passed = 0;

  cache_lookup_req dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .kill_i      (kill),
    .req_o       (req_o),
    .gnt_i       (gnt),
    .addr_o      (addr_o),
    .tag_o       (tag_o),
    .hit_way_i   (hit_way),
    .rdata_i     (rdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_hit_o   (rsp_hit),
    .rsp_err_o   (rsp_err),
    .rsp_way_o   (rsp_way),
    .rsp_data_o  (rsp_data)
  );

  typedef struct {
    logic        hit;
    logic        err;
    logic [7:0]  way;
    logic [63:0] data;
  } exp_t;

  typedef struct {
    int          lat;
    logic        hit;
    logic        err;
    logic [7:0]  way;
    logic [63:0] data;
    logic [43:0] tag;
    bit          req_ok;
    bit          stable_ok;
    bit          idle_after;
  } obs_t;

  function automatic exp_t model(input logic [63:0] a, input logic [7:0] hw,
                                 input cache_line_t [7:0] ln);
    exp_t e;
    int   n;
    e.hit = 1'b0; e.err = 1'b0; e.way = 8'h00; e.data = 64'h0;
    n = $countones(hw);
    if (n > 1) begin
      e.err = 1'b1;
    end else if (n == 1) begin
      e.hit = 1'b1;
      e.way = hw;
      for (int i = 0; i < 8; i++)
        if (hw[i]) e.data = ln[i].data[64*int'(a[3]) +: 64];
    end
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_lines();
    for (int i = 0; i < 8; i++) begin
      rdata[i].tag   = 44'({$urandom, $urandom});
      rdata[i].data  = {$urandom, $urandom, $urandom, $urandom};
      rdata[i].valid = 1'b1;
      rdata[i].dirty = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_lookup(input logic [63:0] a, input int gdly,
                           input int rdly, input bit kill_acc,
                           output obs_t o);
    int c;
    o = '{default: 0};
    o.lat = -1; o.req_ok = 1; o.stable_ok = 1;
    cyc();
    req_valid = 1'b1; req_addr = a; kill = kill_acc;
    @(negedge clk);
    if (req_ready !== 1'b1) o.req_ok = 0;
    cyc();
    req_valid = 1'b0; kill = 1'b0; req_addr = {$urandom, $urandom};
    for (int g = 0; g <= gdly; g++) begin
      gnt = (g == gdly);
      @(negedge clk);
      if (req_o !== 8'hFF || addr_o !== a[11:0] || req_ready !== 1'b0)
        o.req_ok = 0;
      cyc();
    end
    gnt = 1'b0;
    @(negedge clk);
    o.tag = tag_o;
    c = 2 + gdly;
    for (int k = 0; k < 10 && o.lat < 0; k++) begin
      cyc();
      c++;
      @(negedge clk);
      if (rsp_valid === 1'b1) o.lat = c;
    end
    if (o.lat < 0) return;
    o.hit = rsp_hit; o.err = rsp_err; o.way = rsp_way; o.data = rsp_data;
    for (int r = 1; r <= rdly; r++) begin
      cyc();
      @(negedge clk);
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
          {rsp_hit, rsp_err, rsp_way, rsp_data} !==
          {o.hit, o.err, o.way, o.data})
        o.stable_ok = 0;
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    @(negedge clk);
    o.idle_after = (req_ready === 1'b1) && (rsp_valid === 1'b0);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_o, rsp_valid, tag_o, addr_o} !== '0)
      $display("FAIL reset_port: got req=%h v=%b tag=%h addr=%h want 0",
               req_o, rsp_valid, tag_o, addr_o);
    else passed++;
    checks++;
    if ({rsp_hit, rsp_err, rsp_way, rsp_data} !== '0)
      $display("FAIL reset_rsp: got hit=%b err=%b way=%h data=%h want 0",
               rsp_hit, rsp_err, rsp_way, rsp_data);
    else passed++;
    rst_ni = 1'b1;
    cyc();
    checks++;
    if (req_ready !== 1'b1)
      $display("FAIL reset_ready: got %b want 1", req_ready);
    else passed++;
  endtask

  task automatic test_directed();
    obs_t o;
    rand_lines();
    rdata[2].data = {64'h0000_0000_DEAD_BEEF, 64'h0123_4567_89AB_CDEF};
    hit_way = 8'h04;
    do_lookup(64'h0000_0000_8000_1238, 0, 0, 1'b0, o);
    checks++;
    if (o.lat !== 3) $display("FAIL dir_lat: got %0d want 3", o.lat);
    else passed++;
    checks++;
    if (o.hit !== 1'b1 || o.err !== 1'b0)
      $display("FAIL dir_hit: got hit=%b err=%b want 1/0", o.hit, o.err);
    else passed++;
    checks++;
    if (o.way !== 8'h04) $display("FAIL dir_way: got %h want 04", o.way);
    else passed++;
    checks++;
    if (o.data !== 64'hDEAD_BEEF)
      $display("FAIL dir_data: got %h want deadbeef", o.data);
    else passed++;
    checks++;
    if (o.tag !== 44'h80001)
      $display("FAIL dir_tag: got %h want 80001", o.tag);
    else passed++;
    checks++;
    if (!o.req_ok || !o.idle_after)
      $display("FAIL dir_proto: got req_ok=%0d idle=%0d want 1/1",
               o.req_ok, o.idle_after);
    else passed++;
  endtask

  task automatic test_gnt_delay();
    obs_t o;
    logic [63:0] a;
    rand_lines();
    hit_way = 8'h80;
    a = {$urandom, $urandom};
    do_lookup(a, 4, 0, 1'b0, o);
    checks++;
    if (!o.req_ok)
      $display("FAIL gnt_hold: got req_o/addr_o unstable want stable");
    else passed++;
    checks++;
    if (o.lat !== 7) $display("FAIL gnt_lat: got %0d want 7", o.lat);
    else passed++;
  endtask

  task automatic test_miss_err();
    obs_t o;
    rand_lines();
    hit_way = 8'h00;
    do_lookup({$urandom, $urandom}, 0, 0, 1'b0, o);
    checks++;
    if ({o.hit, o.err, o.way, o.data} !== '0)
      $display("FAIL miss: got hit=%b err=%b way=%h data=%h want 0",
               o.hit, o.err, o.way, o.data);
    else passed++;
    hit_way = 8'h11;
    do_lookup({$urandom, $urandom}, 1, 0, 1'b0, o);
    checks++;
    if ({o.hit, o.err, o.way, o.data} !== {1'b0, 1'b1, 8'h00, 64'h0})
      $display("FAIL multi: got hit=%b err=%b way=%h data=%h want 0/1/0/0",
               o.hit, o.err, o.way, o.data);
    else passed++;
  endtask

  task automatic test_backpressure();
    obs_t o;
    exp_t e;
    logic [63:0] a;
    rand_lines();
    hit_way = 8'h20;
    a = {$urandom, $urandom};
    e = model(a, hit_way, rdata);
    do_lookup(a, 0, 3, 1'b0, o);
    checks++;
    if (!o.stable_ok)
      $display("FAIL bp_stable: got outputs changed want held");
    else passed++;
    checks++;
    if (!o.idle_after)
      $display("FAIL bp_release: got ready=0 after handshake want 1");
    else passed++;
    checks++;
    if (o.data !== e.data) $display("FAIL bp_data: got %h want %h", o.data, e.data);
    else passed++;
  endtask

  task automatic test_kill_idle();
    obs_t o;
    exp_t e;
    logic [63:0] a;
    rand_lines();
    hit_way = 8'h08;
    a = {$urandom, $urandom};
    e = model(a, hit_way, rdata);
    do_lookup(a, 0, 0, 1'b1, o);
    checks++;
    if (o.lat !== 3) $display("FAIL kill_idle_lat: got %0d want 3", o.lat);
    else passed++;
    checks++;
    if ({o.hit, o.data} !== {e.hit, e.data})
      $display("FAIL kill_idle_rsp: got %b/%h want %b/%h",
               o.hit, o.data, e.hit, e.data);
    else passed++;
  endtask

  task automatic test_kill();
    bit seen;
    logic [63:0] a;
    a = {$urandom, $urandom};
    hit_way = 8'h02;
    cyc(); req_valid = 1'b1; req_addr = a; gnt = 1'b0;
    cyc(); req_valid = 1'b0;
    cyc(); kill = 1'b1;
    @(negedge clk);
    checks++;
    if (req_o !== 8'h00 || rsp_valid !== 1'b0)
      $display("FAIL kill_req_now: got req=%h v=%b want 00/0", req_o, rsp_valid);
    else passed++;
    cyc(); kill = 1'b0; gnt = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1)
      $display("FAIL kill_req_ready: got %b want 1", req_ready);
    else passed++;
    seen = 0;
    repeat (5) begin
      cyc();
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_o !== 8'h00) seen = 1;
    end
    gnt = 1'b0;
    checks++;
    if (seen) $display("FAIL kill_req_quiet: got activity want none");
    else passed++;
    cyc(); req_valid = 1'b1; req_addr = a;
    cyc(); req_valid = 1'b0; gnt = 1'b1;
    cyc(); gnt = 1'b0; kill = 1'b1;
    @(negedge clk);
    checks++;
    if (tag_o !== a[55:12] || rsp_valid !== 1'b0)
      $display("FAIL kill_cmp: got tag=%h v=%b want %h/0", tag_o, rsp_valid, a[55:12]);
    else passed++;
    cyc(); kill = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) seen = 1;
      cyc();
    end
    checks++;
    if (seen) $display("FAIL kill_cmp_quiet: got activity want idle");
    else passed++;
    req_valid = 1'b1; req_addr = a;
    cyc(); req_valid = 1'b0; gnt = 1'b1;
    cyc(); gnt = 1'b0;
    cyc();
    @(negedge clk);
    kill = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0)
      $display("FAIL kill_rsp_now: got %b want 0", rsp_valid);
    else passed++;
    cyc(); kill = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL kill_rsp_idle: got rdy=%b v=%b want 1/0", req_ready, rsp_valid);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    logic [63:0] a;
    a = {$urandom | 32'h1000, $urandom | 32'h1};
    hit_way = 8'h01;
    cyc(); req_valid = 1'b1; req_addr = a;
    cyc(); req_valid = 1'b0; gnt = 1'b1;
    cyc(); gnt = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    checks++;
    if ({req_o, rsp_valid, rsp_hit, rsp_err, rsp_way, rsp_data, tag_o, addr_o} !== '0)
      $display("FAIL rst_mid_zero: got tag=%h addr=%h data=%h want 0",
               tag_o, addr_o, rsp_data);
    else passed++;
    cyc();
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1)
      $display("FAIL rst_mid_ready: got %b want 1", req_ready);
    else passed++;
    seen = 0;
    repeat (6) begin
      cyc();
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) $display("FAIL rst_mid_rsp: got response want none");
    else passed++;
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic [63:0] a;
    int gd, rd, i0, i1;
    for (int n = 0; n < 40; n++) begin
      rand_lines();
      a  = {$urandom, $urandom};
      gd = $urandom_range(0, 3);
      rd = $urandom_range(0, 2);
      i0 = $urandom_range(0, 7);
      i1 = (i0 + 1 + $urandom_range(0, 6)) % 8;
      case ($urandom_range(0, 3))
        0:       hit_way = 8'h00;
        3:       hit_way = 8'(1 << i0) | 8'(1 << i1);
        default: hit_way = 8'(1 << i0);
      endcase
      e = model(a, hit_way, rdata);
      do_lookup(a, gd, rd, 1'($urandom_range(0, 1)), o);
      checks++;
      if (o.lat !== 3 + gd)
        $display("FAIL rnd_lat[%0d]: got %0d want %0d", n, o.lat, 3 + gd);
      else passed++;
      checks++;
      if ({o.hit, o.err, o.way, o.data} !== {e.hit, e.err, e.way, e.data})
        $display("FAIL rnd_rsp[%0d]: got %b/%b/%h/%h want %b/%b/%h/%h", n,
                 o.hit, o.err, o.way, o.data, e.hit, e.err, e.way, e.data);
      else passed++;
      checks++;
      if (o.tag !== a[55:12])
        $display("FAIL rnd_tag[%0d]: got %h want %h", n, o.tag, a[55:12]);
      else passed++;
      checks++;
      if (!o.req_ok || !o.stable_ok || !o.idle_after)
        $display("FAIL rnd_proto[%0d]: got %0d%0d%0d want 111", n,
                 o.req_ok, o.stable_ok, o.idle_after);
      else passed++;
    end
  endtask

  initial begin
    rst_ni = 1'b0; req_valid = 1'b0; req_addr = '0; kill = 1'b0;
    gnt = 1'b0; hit_way = '0; rdata = '0; rsp_ready = 1'b0;
    test_reset();
    test_directed();
    test_gnt_delay();
    test_miss_err();
    test_backpressure();
    test_kill_idle();
    test_kill();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cache_lookup_req.md
CACHE_LOOKUP_REQ -- requirements
Module: cache_lookup_req

Interface
REQ-001 Param ADDR_WIDTH, 64, physical address width of client request.
REQ-002 Param DCACHE_SET_ASSOC, 8, number of ways; widths of req_o, hit_way_i, rdata_i, rsp_way_o.
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  in  1  client lookup request valid.
REQ-006 req_ready_o  out  1  block accepts request this cycle.
REQ-007 req_addr_i  in  ADDR_WIDTH  full physical byte address.
REQ-008 kill_i  in  1  abort in-flight lookup.
REQ-009 req_o  out  DCACHE_SET_ASSOC  per-way SRAM request to arbiter port.
REQ-010 gnt_i  in  1  arbiter grant for this port.
REQ-011 addr_o  out  DCACHE_INDEX_WIDTH  index phase address.
REQ-012 tag_o  out  DCACHE_TAG_WIDTH  tag, presented the cycle after grant.
REQ-013 hit_way_i  in  DCACHE_SET_ASSOC  per-way hit from tag compare.
REQ-014 rdata_i  in  DCACHE_SET_ASSOC x cache_line_t  lines read from all ways.
REQ-015 rsp_valid_o / rsp_ready_i  out / in  1 / 1  response handshake.
REQ-016 rsp_hit_o, rsp_err_o  out  1 each  hit; multi-way hit error.
REQ-017 rsp_way_o  out  DCACHE_SET_ASSOC  one-hot hit way, zero on miss/error.
REQ-018 rsp_data_o  out  64  selected 64-bit word of hit line.

Function
REQ-019 FSM states IDLE, REQ, CMP, RSP; req_ready_o SHALL be 1 only in IDLE.
REQ-020 IDLE: on req_valid_i&req_ready_o, register index = addr[DCACHE_INDEX_WIDTH-1:0], tag = addr[DCACHE_TAG_WIDTH+DCACHE_INDEX_WIDTH-1:DCACHE_INDEX_WIDTH], word offset = addr[DCACHE_INDEX_WIDTH-1:3] low DCACHE_OFFSET_WIDTH-3 bits; go REQ.
REQ-021 REQ: req_o all ones, addr_o = registered index; stay until gnt_i; on gnt_i go CMP; req_o SHALL hold stable while ungranted.
REQ-022 CMP: req_o = 0, tag_o = registered tag; sample hit_way_i and rdata_i into response registers; go RSP.
REQ-023 tag_o SHALL carry the registered tag in every state (only CMP-cycle value is meaningful).
REQ-024 Response: exactly one hit bit -> rsp_hit_o=1, rsp_way_o=hit_way_i, rsp_data_o = word[offset] of that way's line data.
REQ-025 Zero hit bits -> rsp_hit_o=0, rsp_err_o=0, rsp_way_o=0, rsp_data_o=0.
REQ-026 More than one hit bit -> rsp_err_o=1, rsp_hit_o=0, rsp_way_o=0, rsp_data_o=0.
REQ-027 RSP: rsp_valid_o=1, outputs stable until rsp_ready_i; on rsp_ready_i go IDLE.
REQ-028 Minimum latency: accept at cycle 0, req_o at cycle 1, gnt at cycle 1, tag_o at cycle 2, rsp_valid_o at cycle 3.
REQ-029 kill_i in REQ/CMP/RSP: go IDLE next cycle, req_o=0 same cycle, rsp_valid_o=0 same cycle; kill in CMP SHALL not affect the tag_o value that cycle.
REQ-030 kill_i in IDLE: ignored; request accepted normally (kill has no effect on new accept).
REQ-031 gnt_i outside REQ SHALL be ignored.

Reset
REQ-032 rst_ni low: state IDLE, all registers zero, req_o=0, rsp_valid_o=0, rsp_hit_o=0, rsp_err_o=0, rsp_way_o=0, rsp_data_o=0, tag_o=0, addr_o=0 asynchronously.
REQ-033 Reset mid-operation SHALL discard the lookup; no response after reset release.
REQ-034 req_ready_o SHALL be 1 in the first cycle after reset release.

Structure
REQ-035 cache_line_t, DCACHE_INDEX_WIDTH, DCACHE_TAG_WIDTH, DCACHE_OFFSET_WIDTH come from existing shared packages (std_cache_pkg, ariane_pkg); no new package types.
REQ-036 FSM state enum is local to the module.
REQ-037 One sub-module: cl_word_sel (one-hot way select, popcount check, 64-bit word extract from cache line).

Verification
REQ-038 Addr 0x8000_1238, gnt immediate, way 2 hits, line word1=0xDEAD_BEEF -> rsp at cycle 3: hit=1, way=0x04, data=0xDEAD_BEEF, err=0.
REQ-039 gnt withheld 4 cycles -> req_o=0xFF, addr_o constant for 4 cycles; rsp_valid_o at cycle 7.
REQ-040 hit_way_i=0x00 -> hit=0, err=0, way=0, data=0; hit_way_i=0x11 -> err=1, hit=0.
REQ-041 rsp_ready_i low 3 cycles -> rsp outputs stable; req_ready_o=0 until cycle after rsp_ready_i.
REQ-042 kill_i in REQ cycle 2 -> req_o=0 same cycle, no rsp_valid_o, req_ready_o=1 next cycle.
REQ-043 rst_ni low during CMP -> all outputs zero immediately; no response after release.
